ks_voice_bank: RTL and testbench

KS_VOICE_BANK -- requirements
Module: ks_voice_bank

---
 rtl/ks_voice_bank.sv | 217 +++++++++++++++++++++
 tb/tb_ks_voice_bank.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_voice_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ks_voice_bank                                                              |
// | Time-multiplexed Karplus-Strong plucked-string voices sharing one RAM.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ks_voice_bank #(
    parameter int DATA_W     = 24,
    parameter int DEPTH_LOG2 = 11,
    parameter int NUM_VOICES = 4,
    parameter int MIN_LEN    = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      sample_tick,
    input  logic [NUM_VOICES-1:0]                     trig,
    input  logic [NUM_VOICES*DEPTH_LOG2-1:0]          len,
    input  logic [1:0]                                octave,
    input  logic [2:0]                                damp,
    input  logic [31:0]                               seed,
    output logic signed [DATA_W+$clog2(NUM_VOICES):0] mix_out,
    output logic                                      mix_valid,
    output logic [NUM_VOICES-1:0]                     busy,
    output logic                                      overrun
);

    localparam int c_VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int c_AW = c_VW + DEPTH_LOG2;
    localparam int c_SW = $clog2(2 * NUM_VOICES + 1);
    localparam int c_MW = DATA_W + $clog2(NUM_VOICES) + 1;
    localparam logic [c_SW-1:0]       c_LAST = c_SW'(2 * NUM_VOICES);
    localparam logic [DEPTH_LOG2-1:0] c_MIN  = DEPTH_LOG2'(MIN_LEN);
    localparam logic [DEPTH_LOG2-1:0] c_ONE  = DEPTH_LOG2'(1);
    localparam logic [31:0]           c_POLY = 32'h8020_0003;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } voice_state_t;

    voice_state_t             r_state [NUM_VOICES];
    logic [DEPTH_LOG2-1:0]    r_ptr   [NUM_VOICES];
    logic signed [DATA_W-1:0] r_xprev [NUM_VOICES];
    logic [NUM_VOICES-1:0]    r_pend;
    logic                     r_active;
    logic [c_SW-1:0]          r_step;
    logic signed [c_MW-1:0]   r_acc;
    logic [31:0]              r_lfsr;
    logic [DEPTH_LOG2-1:0]    r_slot_ptr;
    logic [DEPTH_LOG2-1:0]    r_slot_len;
    logic                     r_slot_restart;
    logic signed [DATA_W-1:0] r_rd_data;
    logic signed [DATA_W-1:0] r_mem [2**c_AW];

    logic [c_VW-1:0]          w_vox;
    logic                     w_in_slots;
    logic                     w_rd_step;
    logic                     w_cmp_step;
    logic [DEPTH_LOG2-1:0]    w_len_v;
    logic [DEPTH_LOG2-1:0]    w_len_sh;
    logic [DEPTH_LOG2-1:0]    w_leff;
    logic [DEPTH_LOG2-1:0]    w_ptr_eff;
    logic [DEPTH_LOG2-1:0]    w_ptr_nxt;
    logic [NUM_VOICES-1:0]    w_consume;
    logic                     w_re;
    logic                     w_we;
    logic [c_AW-1:0]          w_addr;
    voice_state_t             w_slot_state;
    voice_state_t             w_next_state;
    logic signed [DATA_W-1:0] w_noise;
    logic signed [DATA_W:0]   w_sum;
    logic signed [DATA_W-1:0] w_y;
    logic signed [DATA_W-1:0] w_ysh;
    logic signed [DATA_W-1:0] w_yd;
    logic signed [DATA_W-1:0] w_wdata;
    logic signed [DATA_W-1:0] w_contrib;
    logic                     w_lfsr_adv;

    // Even steps issue the voice's RAM read, odd steps compute and write back.
    always_comb begin
        w_vox      = r_step[c_VW:1];
        w_in_slots = r_active && (r_step < c_LAST);
        w_rd_step  = w_in_slots && !r_step[0];
        w_cmp_step = w_in_slots && r_step[0];

        w_len_v  = len[int'(w_vox)*DEPTH_LOG2 +: DEPTH_LOG2];
        w_len_sh = w_len_v >> octave;
        w_leff   = (w_len_sh < c_MIN) ? c_MIN : w_len_sh;

        if (r_pend[w_vox] || (r_ptr[w_vox] >= w_leff)) begin
            w_ptr_eff = '0;
        end else begin
            w_ptr_eff = r_ptr[w_vox];
        end

        w_consume = '0;
        if (w_rd_step) begin
            w_consume[w_vox] = r_pend[w_vox];
        end
        w_re = w_rd_step && !r_pend[w_vox] && (r_state[w_vox] == S_RUN);

        w_slot_state = r_slot_restart ? S_FILL : r_state[w_vox];
        w_ptr_nxt    = (r_slot_ptr == r_slot_len - c_ONE) ? '0 : r_slot_ptr + c_ONE;

        w_noise = r_lfsr[31 -: DATA_W];
        w_sum   = {r_rd_data[DATA_W-1], r_rd_data} + {r_xprev[w_vox][DATA_W-1], r_xprev[w_vox]};
        w_y     = DATA_W'(w_sum >>> 1);
        w_ysh   = w_y >>> ({1'b0, damp} + 4'd3);
        w_yd    = (damp == 3'd0) ? w_y : w_y - w_ysh;

        w_next_state = w_slot_state;
        w_we         = 1'b0;
        w_wdata      = '0;
        w_contrib    = '0;
        w_lfsr_adv   = 1'b0;
        case (w_slot_state)
            S_FILL: begin
                w_we       = w_cmp_step && !reset;
                w_wdata    = w_noise;
                w_contrib  = w_noise;
                w_lfsr_adv = w_cmp_step;
                if (r_slot_ptr == r_slot_len - c_ONE) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                w_we      = w_cmp_step && !reset;
                w_wdata   = w_yd;
                w_contrib = w_yd;
            end
            default: ;
        endcase

        w_addr = {w_vox, (w_rd_step ? w_ptr_eff : r_slot_ptr)};
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_addr] <= w_wdata;
        end
        if (w_re) begin
            r_rd_data <= r_mem[w_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_active       <= 1'b0;
            r_step         <= '0;
            r_acc          <= '0;
            r_pend         <= '0;
            r_lfsr         <= (seed == 32'd0) ? 32'd1 : seed;
            r_slot_ptr     <= '0;
            r_slot_len     <= '0;
            r_slot_restart <= 1'b0;
            mix_out        <= '0;
            mix_valid      <= 1'b0;
            overrun        <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_state[v] <= S_IDLE;
                r_ptr[v]   <= '0;
                r_xprev[v] <= '0;
            end
        end else begin
            mix_valid <= 1'b0;
            // A trig landing on the read step re-arms pending for the next sample.
            r_pend    <= (r_pend & ~w_consume) | trig;

            if (sample_tick && r_active) begin
                overrun <= 1'b1;
            end

            if (r_active) begin
                r_step <= r_step + c_SW'(1);
                if (r_step == c_LAST) begin
                    r_active  <= 1'b0;
                    mix_out   <= r_acc;
                    mix_valid <= 1'b1;
                end
            end else if (sample_tick) begin
                r_active <= 1'b1;
                r_step   <= '0;
                r_acc    <= '0;
            end

            if (w_rd_step) begin
                r_slot_ptr     <= w_ptr_eff;
                r_slot_len     <= w_leff;
                r_slot_restart <= r_pend[w_vox];
            end

            if (w_cmp_step) begin
                r_state[w_vox] <= w_next_state;
                if (w_slot_state != S_IDLE) begin
                    r_ptr[w_vox] <= w_ptr_nxt;
                end
                if (r_slot_restart) begin
                    r_xprev[w_vox] <= '0;
                end else if (w_slot_state == S_RUN) begin
                    r_xprev[w_vox] <= r_rd_data;
                end
                r_acc <= r_acc + c_MW'(w_contrib);
            end

            if (w_lfsr_adv) begin
                r_lfsr <= {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? c_POLY : 32'd0);
            end
        end
    end

    for (genvar gv = 0; gv < NUM_VOICES; gv++) begin : g_busy
        assign busy[gv] = (r_state[gv] != S_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_ks_voice_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ks_voice_bank                                                           |
// | Directed stimulus against a per-sample string model of ks_voice_bank.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ks_voice_bank;

    localparam int DW   = 24;
    localparam int DL   = 11;
    localparam int NV   = 4;
    localparam int MINL = 4;
    localparam int MW   = DW + $clog2(NV) + 1;
    localparam int LAT  = 2 * NV + 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 sample_tick;
    logic [NV-1:0]        trig;
    logic [NV*DL-1:0]     len;
    logic [1:0]           octave;
    logic [2:0]           damp;
    logic [31:0]          seed;
    logic signed [MW-1:0] mix_out;
    logic                 mix_valid;
    logic [NV-1:0]        busy;
    logic                 overrun;

    ks_voice_bank #(
        .DATA_W(DW), .DEPTH_LOG2(DL), .NUM_VOICES(NV), .MIN_LEN(MINL)
    ) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .trig(trig),
        .len(len), .octave(octave), .damp(damp), .seed(seed),
        .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    // String model: one call = one whole output sample for all voices.
    localparam int IDLE = 0, FILL = 1, RUN = 2;
    int          m_st   [NV];
    int          m_ptr  [NV];
    int          m_fc   [NV];
    longint      m_xp   [NV];
    longint      m_buf  [NV][1<<DL];
    logic [NV-1:0] m_pend;
    logic [31:0] m_lfsr;
    longint      m_mix, m_next;
    bit          m_over, m_live = 0;
    int          cd = 0;

    function automatic logic [31:0] f_step(input logic [31:0] s);
        logic [31:0] t;
        // x^32+x^22+x^2+x+1, shifting right; the bit leaving bit 0 feeds 31,21,1,0
        t = s >> 1;
        if (s[0]) t = t ^ 32'h8020_0003;
        return t;
    endfunction

    function automatic longint f_noise(input logic [31:0] s);
        logic signed [DW-1:0] t;
        t = s[31 -: DW];
        return longint'(t);
    endfunction

    function automatic longint f_karplus(input longint x, input longint xp, input int d);
        longint y;
        y = (x + xp) >>> 1;
        if (d == 0) return y;
        return y - (y >>> (d + 3));
    endfunction

    task automatic model_sample();
        longint acc, n, x;
        logic [DL-1:0] lv;
        int L;
        acc = 0;
        for (int v = 0; v < NV; v++) begin
            lv = len[v*DL +: DL];
            L  = int'(lv) >> octave;
            if (L < MINL) L = MINL;
            if (m_pend[v]) begin
                m_st[v] = FILL; m_ptr[v] = 0; m_xp[v] = 0; m_fc[v] = 0; m_pend[v] = 1'b0;
            end
            if (m_ptr[v] >= L) m_ptr[v] = 0;
            if (m_st[v] == FILL) begin
                n = f_noise(m_lfsr);
                m_buf[v][m_ptr[v]] = n;
                acc += n;
                m_lfsr = f_step(m_lfsr);
                m_fc[v]++;
                if (m_fc[v] == L) m_st[v] = RUN;
                m_ptr[v] = (m_ptr[v] + 1) % L;
            end else if (m_st[v] == RUN) begin
                x = m_buf[v][m_ptr[v]];
                n = f_karplus(x, m_xp[v], int'(damp));
                m_buf[v][m_ptr[v]] = n;
                m_xp[v] = x;
                acc += n;
                m_ptr[v] = (m_ptr[v] + 1) % L;
            end
        end
        m_next = acc;
    endtask

    // Per-cycle compare against the model.
    initial begin
        logic tk, rs;
        logic [NV-1:0] tg, exp_busy;
        logic [31:0] sd;
        bit exp_valid;
        forever begin
            @(posedge clk);
            tk = sample_tick; tg = trig; rs = reset; sd = seed;
            #2;
            exp_valid = 1'b0;
            if (rs) begin
                m_live = 1; cd = 0; m_over = 0; m_mix = 0; m_pend = '0;
                m_lfsr = (sd == 32'd0) ? 32'd1 : sd;
                for (int v = 0; v < NV; v++) begin
                    m_st[v] = IDLE; m_ptr[v] = 0; m_xp[v] = 0; m_fc[v] = 0;
                end
            end else if (m_live) begin
                m_pend = m_pend | tg;
                if (cd > 0) begin
                    if (tk) m_over = 1;
                    cd--;
                    if (cd == 0) begin
                        exp_valid = 1'b1;
                        m_mix     = m_next;
                    end
                end else if (tk) begin
                    model_sample();
                    cd = LAT;
                end
            end
            if (m_live) begin
                check("mix_valid", longint'(mix_valid), longint'(exp_valid));
                check("mix_out", longint'(mix_out), m_mix);
                check("overrun", longint'(overrun), longint'(m_over));
                if (cd == 0) begin
                    for (int v = 0; v < NV; v++) exp_busy[v] = (m_st[v] != IDLE);
                    check("busy", longint'(busy), longint'(exp_busy));
                end
            end
        end
    end

    task automatic do_tick(output longint got);
        bit seen;
        seen = 0; got = 0;
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk);
            if (mix_valid) begin
                seen = 1;
                got  = longint'(mix_out);
            end
        end
        if (!seen) begin
            vectors++; errors++;
            $display("FAIL tick_timeout: mix_valid got 0, required 1");
        end
    endtask

    task automatic pulse_trig(input logic [NV-1:0] m);
        @(negedge clk); trig = m;
        @(negedge clk); trig = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint got;
        reset = 1'b1; sample_tick = 1'b0; trig = '0; octave = 2'd0; damp = 3'd0;
        seed = 32'h1234_5678;
        for (int v = 0; v < NV; v++) len[v*DL +: DL] = DL'(8);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_mix", longint'(mix_out), 0);
        check("reset_busy", longint'(busy), 0);

        for (int i = 0; i < 3; i++) begin
            do_tick(got);
            check("idle_mix", got, 0);
            check("idle_busy", longint'(busy), 0);
        end

        check("pin_damp_1000", f_karplus(1000, 1000, 1), 938);
        check("pin_avg_neg", f_karplus(-3, 0, 0), -2);
        check("pin_damp_minus1", f_karplus(-1, 0, 2), 0);

        pulse_trig(4'b0001);
        do_tick(got);
        check("fill_noise_0", got, 1193046);
        check("busy_after_trig", longint'(busy), 1);
        do_tick(got);
        check("fill_noise_1", got, 596523);
        repeat (18) do_tick(got);

        octave = 2'd2;
        len[1*DL +: DL] = DL'(40);
        len[2*DL +: DL] = DL'(2);
        len[3*DL +: DL] = DL'(60);
        pulse_trig(4'b0110);
        repeat (24) do_tick(got);

        damp = 3'd1;
        pulse_trig(4'b1000);
        repeat (20) do_tick(got);

        pulse_trig(4'b0001);
        repeat (9) do_tick(got);
        damp = 3'd7;
        repeat (6) do_tick(got);
        damp = 3'd0;

        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        @(negedge clk);
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        repeat (12) @(negedge clk);
        check("overrun_set", longint'(overrun), 1);
        do_tick(got);
        check("overrun_sticky", longint'(overrun), 1);

        seed = 32'd0; reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("overrun_cleared", longint'(overrun), 0);
        pulse_trig(4'b0001);
        do_tick(got);
        check("seed0_noise_0", got, 0);
        do_tick(got);
        check("seed0_noise_1", got, -8380416);
        repeat (4) do_tick(got);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
